ex_div_ctrl: RTL

EX_DIV_CTRL -- requirements
Module: ex_div_ctrl

---
 rtl/ex_div_pkg.sv | 20 ++
 rtl/div_restore_step.sv | 30 +++
 rtl/ex_div_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage iterative divider.
// Optional build macro used by ex_div_ctrl: EX_DIV_ZERO_FAST_EN.
package ex_div_pkg;

  // Divider control states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  // Two's-complement magnitude of a value that is negative when neg is set
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring shift-subtract iteration of a 32-bit unsigned divide.
// The quotient register doubles as the dividend shift register: its MSB
// feeds the partial remainder and the new quotient bit enters at its LSB.
module div_restore_step
  import ex_div_pkg::*;
(
  input  logic [31:0] rem_in,
  input  logic [31:0] quo_in,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic [31:0] quo_out
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // Trial subtract; keep the difference only when it does not go negative
  always_comb begin
    shifted = {rem_in, quo_in[31]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[32]) begin
      rem_out = diff[31:0];
      quo_out = {quo_in[30:0], 1'b1};
    end else begin
      rem_out = shifted[31:0];
      quo_out = {quo_in[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_ctrl.sv
// EX-stage divider controller: stalls the EX stage while a 32-cycle restoring
// divide runs, then holds the result until MEM accepts it.
// Build macro EX_DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle.
// Handshake: ex_ready_go is high whenever EX does not hold a divide, or the
// divide is in DONE; the hand-off happens in a cycle where ex_ready_go and
// mem_allowin are both high, and only then does DONE return to IDLE.
module ex_div_ctrl
  import ex_div_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             ex_valid,
  input  logic             ex_is_div,
  input  logic             ex_div_signed,
  input  logic             ex_div_mod,
  input  logic [31:0]      ex_div_src1,
  input  logic [31:0]      ex_div_src2,
  input  logic             mem_allowin,
  output logic             ex_ready_go,
  output logic [31:0]      div_result,
  output logic             div_busy,
  output div_state_e       dbg_state
);

`ifdef EX_DIV_ZERO_FAST_EN
  localparam logic ZERO_FAST = 1'b1;
`else
  localparam logic ZERO_FAST = 1'b0;
`endif

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             mod_q, mod_d;
  logic             zero_q, zero_d;
  logic [31:0]      result_q, result_d;

  logic [31:0]      step_rem;
  logic [31:0]      step_quo;
  logic             start;
  logic             a_neg;
  logic             b_neg;
  logic [31:0]      q_final;
  logic [31:0]      r_final;

  div_restore_step u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Next-state, operand capture and result selection
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    mod_d    = mod_q;
    zero_d   = zero_q;
    result_d = result_q;

    start = ex_valid & ex_is_div;
    a_neg = ex_div_signed & ex_div_src1[31];
    b_neg = ex_div_signed & ex_div_src2[31];

    // A zero divisor forces an all-ones quotient regardless of signs; the
    // remainder naturally comes out as the dividend after sign restore.
    q_final = zero_q ? ALL_ONES : mag32(step_quo, q_neg_q);
    r_final = mag32(step_rem, r_neg_q);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          rem_d   = '0;
          quo_d   = mag32(ex_div_src1, a_neg);
          dvsr_d  = mag32(ex_div_src2, b_neg);
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          mod_d   = ex_div_mod;
          zero_d  = (ex_div_src2 == 32'd0);
          if (ZERO_FAST && (ex_div_src2 == 32'd0)) begin
            state_d  = S_DONE;
            result_d = ex_div_mod ? ex_div_src1 : ALL_ONES;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = mod_q ? r_final : q_final;
        end
      end
      S_DONE: begin
        if (mem_allowin) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight divide
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      mod_q    <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      mod_q    <= mod_d;
      zero_q   <= zero_d;
      result_q <= result_d;
    end
  end

  assign ex_ready_go = ~(ex_valid & ex_is_div) | (state_q == S_DONE);
  assign div_result  = result_q;
  assign div_busy    = (state_q != S_IDLE);
  assign dbg_state   = state_q;

endmodule
